stack_sequencer: RTL and testbench
==================================

STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 SHALL have port: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have port: reset_n  in  1  synchronous, active-low reset.
REQ-003 SHALL have port: ce  in  1  clock enable; state advances and bus_ack is sampled only when ce=1.
REQ-004 SHALL have ports: start  in  1  request pulse; push_mask  in  16  STACK_* push set; pop_mask  in  16  STACK_* pop set; sp_in  in  16  SP at start.
REQ-005 SHALL have ports: bus_req  out  1; bus_write  out  1; bus_addr  out  16  SS offset; bus_wdata  out  16; bus_ack  in  1; bus_rdata  in  16.
REQ-006 SHALL have ports: reg_sel  out  16  one-hot current item; reg_wdata  in  16  register-file value for reg_sel.
REQ-007 SHALL have ports: wb_valid  out  1; wb_sel  out  16  one-hot; wb_data  out  16.
REQ-008 SHALL have ports: busy  out  1; done  out  1; sp_we  out  1; sp_out  out  16; xfer_count  out  16.

Function
REQ-009 SHALL implement states IDLE, POP, PUSH, DONE; busy=1 in every state except IDLE.
REQ-010 SHALL accept start only in IDLE with ce=1: capture both masks and sp_in; go to POP if pop_mask!=0, else PUSH if push_mask!=0, else DONE; start outside IDLE ignored.
REQ-011 SHALL process pop items in descending bit order (bit 15 first), then push items in ascending bit order (bit 0 first).
REQ-012 SHALL skip, with no bus cycle, push bit 5 (SP_DISCARD) and pop bit 4 (SP).
REQ-013 SHALL, per push item, drive bus_req=1, bus_write=1, bus_addr=SP-2 (mod 2^16), bus_wdata=reg_wdata (captured sp_in for bit 4), and set SP=SP-2 on ack.
REQ-014 SHALL, per pop item, drive bus_req=1, bus_write=0, bus_addr=SP, and set SP=SP+2 (mod 2^16) on ack.
REQ-015 SHALL hold bus_req, bus_write, bus_addr, bus_wdata, reg_sel stable until bus_ack=1 on a ce cycle; the next item's bus cycle starts the following ce cycle with no idle gap.
REQ-016 SHALL, one ce cycle after each pop ack except bit 5, pulse wb_valid=1 for one ce cycle with wb_sel=item, wb_data=captured bus_rdata; bit-5 pops produce no writeback.
REQ-017 SHALL drive reg_sel=0 and bus_req=0 in IDLE and DONE.
REQ-018 SHALL, in DONE, assert done=1 and sp_we=1 for exactly one ce cycle with sp_out=final SP, then return to IDLE.
REQ-019 SHALL reach DONE one ce cycle after start when both masks are zero, with sp_out=sp_in and no bus cycle.
REQ-020 SHALL hold all outputs constant while ce=0.

Reset
REQ-021 SHALL, on clk edge with reset_n=0, regardless of state or ce, enter IDLE and clear busy, done, bus_req, bus_write, bus_addr, bus_wdata, reg_sel, wb_valid, wb_sel, wb_data, sp_we, sp_out, xfer_count to 0.
REQ-022 SHALL abandon an in-flight transfer on reset without writeback or sp_we.

Configuration
REQ-023 SHALL, with macro STACK_SEQ_STATS_EN defined, increment xfer_count on every acked bus cycle, saturating at 0xFFFF, cleared only by reset.
REQ-024 SHALL, without STACK_SEQ_STATS_EN, tie xfer_count to 0 with no counter logic.

Verification
REQ-025 PUSH R: push_mask=0x01DF, sp_in=0x1000, ack each cycle -> 8 writes at 0x0FFE..0x0FF0 in order AW,CW,DW,BW,SP,BP,IX,IY; SP slot data 0x1000; done with sp_out=0x0FF0.
REQ-026 POP R: pop_mask=0x01EF, sp_in=0x0FF0 -> 8 reads 0x0FF0..0x0FFE in order IY,IX,BP,discard,BW,DW,CW,AW; 7 wb_valid pulses; sp_out=0x1000.
REQ-027 Wrap: push_mask=0x4C00, sp_in=0x0001 -> writes PSW@0xFFFF, PS@0xFFFD, PC@0xFFFB; sp_out=0xFFFB.
REQ-028 Stall: bus_ack low 5 cycles with ce toggling every cycle -> bus_req/addr/wdata/reg_sel unchanged; advance only on ack with ce=1.
REQ-029 Empty: start with both masks 0, sp_in=0x1234 -> no bus_req; done and sp_we one ce cycle later, sp_out=0x1234.
REQ-030 Reset mid-op: reset_n=0 during third transfer of REQ-025 -> next edge all outputs 0, IDLE, no done; new start then runs normally.

Source files
------------

// File: rtl/stack_sequencer_if.sv
// Stack bus between the sequencer (master) and the stack-segment memory (slave).
// The master holds a request stable until it is acknowledged on a clock-enabled cycle.
interface stack_sequencer_if;
   logic        bus_req;
   logic        bus_write;
   logic [15:0] bus_addr;
   logic [15:0] bus_wdata;
   logic        bus_ack;
   logic [15:0] bus_rdata;

   modport master (
      output bus_req, bus_write, bus_addr, bus_wdata,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_write, bus_addr, bus_wdata,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/stack_sequencer.sv
// Multi-register PUSH/POP sequencer: pops high-to-low, then pushes low-to-high, one bus cycle per item.
// Optional STACK_SEQ_STATS_EN adds a saturating acked-transfer counter on xfer_count.
module stack_sequencer (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               ce,
   input  logic               start,
   input  logic [15:0]        push_mask,
   input  logic [15:0]        pop_mask,
   input  logic [15:0]        sp_in,
   stack_sequencer_if.master  bus,
   output logic [15:0]        reg_sel,
   input  logic [15:0]        reg_wdata,
   output logic               wb_valid,
   output logic [15:0]        wb_sel,
   output logic [15:0]        wb_data,
   output logic               busy,
   output logic               done,
   output logic               sp_we,
   output logic [15:0]        sp_out,
   output logic [15:0]        xfer_count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_POP  = 2'd1;
   localparam logic [1:0] S_PUSH = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   // Pop of SP (bit 4) and push of SP_DISCARD (bit 5) never touch the bus.
   localparam logic [15:0] POP_SKIP  = 16'h0010;
   localparam logic [15:0] PUSH_SKIP = 16'h0020;

   logic [1:0]  r_state;
   logic [15:0] r_pop_rem;
   logic [15:0] r_push_rem;
   logic [15:0] r_sp;
   logic [15:0] r_sp_in;
   logic        r_wb_valid;
   logic [15:0] r_wb_sel;
   logic [15:0] r_wb_data;

   logic [15:0] w_pop_eff;
   logic [15:0] w_push_eff;
   logic [3:0]  w_pop_idx;
   logic [3:0]  w_push_idx;
   logic [3:0]  w_item_idx;
   logic        w_active;
   logic [15:0] w_item_oh;
   logic [15:0] w_pop_next;
   logic [15:0] w_push_next;
   logic        w_ack;

   assign w_pop_eff  = pop_mask & ~POP_SKIP;
   assign w_push_eff = push_mask & ~PUSH_SKIP;

   always_comb begin
      w_pop_idx  = 4'd0;
      w_push_idx = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (r_pop_rem[i]) w_pop_idx = 4'(i);
      end
      for (int i = 15; i >= 0; i--) begin
         if (r_push_rem[i]) w_push_idx = 4'(i);
      end
   end

   assign w_active    = (r_state == S_POP) || (r_state == S_PUSH);
   assign w_item_idx  = (r_state == S_POP) ? w_pop_idx : w_push_idx;
   assign w_item_oh   = w_active ? (16'd1 << w_item_idx) : 16'd0;
   assign w_pop_next  = r_pop_rem & ~w_item_oh;
   assign w_push_next = r_push_rem & ~w_item_oh;
   assign w_ack       = ce && w_active && bus.bus_ack;

   // Bus outputs decode straight from held state, so the next item appears right after an ack.
   assign bus.bus_req   = w_active;
   assign bus.bus_write = (r_state == S_PUSH);
   assign bus.bus_addr  = (r_state == S_PUSH) ? (r_sp - 16'd2) :
                          (r_state == S_POP)  ? r_sp : 16'd0;
   assign bus.bus_wdata = (r_state != S_PUSH) ? 16'd0 :
                          (w_push_idx == 4'd4) ? r_sp_in : reg_wdata;
   assign reg_sel       = w_item_oh;

   assign busy     = (r_state != S_IDLE);
   assign done     = (r_state == S_DONE);
   assign sp_we    = (r_state == S_DONE);
   assign sp_out   = (r_state == S_DONE) ? r_sp : 16'd0;
   assign wb_valid = r_wb_valid;
   assign wb_sel   = r_wb_sel;
   assign wb_data  = r_wb_data;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_pop_rem  <= 16'd0;
         r_push_rem <= 16'd0;
         r_sp       <= 16'd0;
         r_sp_in    <= 16'd0;
         r_wb_valid <= 1'b0;
         r_wb_sel   <= 16'd0;
         r_wb_data  <= 16'd0;
      end else if (ce) begin
         r_wb_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_pop_rem  <= w_pop_eff;
                  r_push_rem <= w_push_eff;
                  r_sp       <= sp_in;
                  r_sp_in    <= sp_in;
                  r_state    <= (w_pop_eff != 16'd0)  ? S_POP  :
                                (w_push_eff != 16'd0) ? S_PUSH : S_DONE;
               end
            end
            S_POP: begin
               if (bus.bus_ack) begin
                  r_sp      <= r_sp + 16'd2;
                  r_pop_rem <= w_pop_next;
                  // A popped SP_DISCARD slot is consumed but never written back.
                  if (w_item_idx != 4'd5) begin
                     r_wb_valid <= 1'b1;
                     r_wb_sel   <= w_item_oh;
                     r_wb_data  <= bus.bus_rdata;
                  end
                  if (w_pop_next == 16'd0)
                     r_state <= (r_push_rem != 16'd0) ? S_PUSH : S_DONE;
               end
            end
            S_PUSH: begin
               if (bus.bus_ack) begin
                  r_sp       <= r_sp - 16'd2;
                  r_push_rem <= w_push_next;
                  if (w_push_next == 16'd0)
                     r_state <= S_DONE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef STACK_SEQ_STATS_EN
   logic [15:0] r_xfer_count;

   always_ff @(posedge clk) begin
      if (!reset_n)
         r_xfer_count <= 16'd0;
      else if (w_ack && (r_xfer_count != 16'hFFFF))
         r_xfer_count <= r_xfer_count + 16'd1;
   end

   assign xfer_count = r_xfer_count;
`else
   assign xfer_count = 16'd0;
`endif

endmodule

// File: tb/tb_stack_sequencer.sv
// Scoreboard bench for stack_sequencer: directed transfers queue expectations, a negedge monitor checks them.
module tb_stack_sequencer;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ce = 1'b1;
   logic        start = 1'b0;
   logic [15:0] push_mask = 16'd0;
   logic [15:0] pop_mask = 16'd0;
   logic [15:0] sp_in = 16'd0;
   logic [15:0] reg_sel, reg_wdata, wb_sel, wb_data, sp_out, xfer_count;
   logic        wb_valid, busy, done, sp_we;

   stack_sequencer_if bif();

   stack_sequencer dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ce         (ce),
      .start      (start),
      .push_mask  (push_mask),
      .pop_mask   (pop_mask),
      .sp_in      (sp_in),
      .bus        (bif.master),
      .reg_sel    (reg_sel),
      .reg_wdata  (reg_wdata),
      .wb_valid   (wb_valid),
      .wb_sel     (wb_sel),
      .wb_data    (wb_data),
      .busy       (busy),
      .done       (done),
      .sp_we      (sp_we),
      .sp_out     (sp_out),
      .xfer_count (xfer_count)
   );

   always #5 clk = ~clk;

   // Register file: register i holds 0xA0i0.
   always_comb begin
      reg_wdata = 16'd0;
      for (int i = 0; i < 16; i++) begin
         if (reg_sel[i]) reg_wdata = 16'hA000 | 16'(i << 4);
      end
   end

   logic [15:0] mem [0:65535];
   assign bif.bus_rdata = mem[bif.bus_addr];
   always @(posedge clk) begin
      if (reset_n && ce && bif.bus_req && bif.bus_ack && bif.bus_write)
         mem[bif.bus_addr] <= bif.bus_wdata;
   end

   typedef struct packed {
      logic        w;
      logic [15:0] a;
      logic [15:0] d;
      logic [15:0] s;
   } bus_exp_t;

   typedef struct packed {
      logic [15:0] sel;
      logic [15:0] data;
   } wb_exp_t;

   bus_exp_t    bus_q[$];
   wb_exp_t     wb_q[$];
   logic [15:0] done_q[$];

   int n_pass = 0;
   int n_total = 0;
   int n_wb = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   task automatic exp_bus(input logic w, input logic [15:0] a, input logic [15:0] d, input logic [15:0] s);
      bus_exp_t e;
      e.w = w; e.a = a; e.d = w ? d : 16'd0; e.s = s;
      bus_q.push_back(e);
   endtask

   task automatic exp_wb(input logic [15:0] sel, input logic [15:0] data);
      wb_exp_t e;
      e.sel = sel; e.data = data;
      wb_q.push_back(e);
   endtask

   // Monitor: a handshake/pulse seen at negedge with ce=1 is consumed by the next rising edge.
   always @(negedge clk) begin
      if (reset_n && ce) begin
         if (bif.bus_req && bif.bus_ack) begin
            if (bus_q.size() == 0) begin
               n_total++;
               $display("FAIL bus_unexpected: got addr %h sel %h, expected no bus cycle", bif.bus_addr, reg_sel);
            end else begin
               bus_exp_t e;
               e = bus_q.pop_front();
               check("bus_item", 64'({bif.bus_write, bif.bus_addr, (bif.bus_write ? bif.bus_wdata : 16'd0), reg_sel}),
                     64'({e.w, e.a, e.d, e.s}));
            end
         end
         if (wb_valid) begin
            n_wb++;
            if (wb_q.size() == 0) begin
               n_total++;
               $display("FAIL wb_unexpected: got sel %h data %h, expected no writeback", wb_sel, wb_data);
            end else begin
               wb_exp_t e;
               e = wb_q.pop_front();
               check("wb_item", 64'({wb_sel, wb_data}), 64'({e.sel, e.data}));
            end
         end
         if (done) begin
            if (done_q.size() == 0) begin
               n_total++;
               $display("FAIL done_unexpected: got done with sp_out %h, expected none", sp_out);
            end else begin
               logic [15:0] e;
               e = done_q.pop_front();
               check("done_sp", 64'({sp_we, sp_out}), 64'({1'b1, e}));
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [15:0] pu, input logic [15:0] po, input logic [15:0] sp);
      start = 1'b1; push_mask = pu; pop_mask = po; sp_in = sp;
      tick();
      start = 1'b0; push_mask = 16'd0; pop_mask = 16'd0; sp_in = 16'd0;
   endtask

   task automatic wait_idle(input string name);
      int cyc;
      cyc = 0;
      while (busy && cyc < 300) begin
         tick();
         cyc++;
      end
      if (cyc >= 300) begin
         n_total++;
         $display("FAIL %s_timeout: busy still %b after %0d cycles, required 0", name, busy, cyc);
      end
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_ctl"}, 64'({busy, done, sp_we, wb_valid, bif.bus_req, bif.bus_write,
                                 bif.bus_addr, bif.bus_wdata, reg_sel}), 64'd0);
      check({name, "_dat"}, 64'({wb_sel, wb_data, sp_out, xfer_count}), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int pr[8];
      int pp[8];
      logic [63:0] snap;
      int wb_before;
      pr = '{0, 1, 2, 3, 4, 6, 7, 8};
      pp = '{8, 7, 6, 5, 3, 2, 1, 0};
      bif.bus_ack = 1'b1;

      repeat (3) tick();
      check_all_zero("reset");
      reset_n = 1'b1;
      tick();

      // Empty request: DONE straight after start.
      done_q.push_back(16'h1234);
      do_start(16'h0000, 16'h0000, 16'h1234);
      check("empty_done", 64'({done, sp_we, bif.bus_req, busy}), 64'(4'b1101));
      check("empty_sp", 64'(sp_out), 64'(16'h1234));
      tick();
      check("empty_back_idle", 64'({busy, done, sp_we}), 64'd0);

      // PUSH R
      for (int k = 0; k < 8; k++)
         exp_bus(1'b1, 16'h0FFE - 16'(2 * k), (pr[k] == 4) ? 16'h1000 : (16'hA000 | 16'(pr[k] << 4)), 16'(1 << pr[k]));
      done_q.push_back(16'h0FF0);
      do_start(16'h01DF, 16'h0000, 16'h1000);
      wait_idle("push_r");
      check("push_sp_slot_mem", 64'(mem[16'h0FF6]), 64'(16'h1000));

      // POP R
      for (int k = 0; k < 8; k++) begin
         exp_bus(1'b0, 16'h0FF0 + 16'(2 * k), 16'd0, 16'(1 << pp[k]));
         if (pp[k] != 5) exp_wb(16'(1 << pp[k]), 16'hA000 | 16'(pp[k] << 4));
      end
      done_q.push_back(16'h1000);
      wb_before = n_wb;
      do_start(16'h0000, 16'h01EF, 16'h0FF0);
      wait_idle("pop_r");
      tick();
      check("pop_wb_count", 64'(n_wb - wb_before), 64'd7);

      // Wrap below zero
      exp_bus(1'b1, 16'hFFFF, 16'hA0A0, 16'h0400);
      exp_bus(1'b1, 16'hFFFD, 16'hA0B0, 16'h0800);
      exp_bus(1'b1, 16'hFFFB, 16'hA0E0, 16'h4000);
      done_q.push_back(16'hFFFB);
      do_start(16'h4C00, 16'h0000, 16'h0001);
      wait_idle("wrap");

      // Stall with ce toggling
      bif.bus_ack = 1'b0;
      exp_bus(1'b1, 16'h1FFE, 16'hA000, 16'h0001);
      exp_bus(1'b1, 16'h1FFC, 16'hA010, 16'h0002);
      done_q.push_back(16'h1FFC);
      do_start(16'h0003, 16'h0000, 16'h2000);
      snap = 64'({bif.bus_req, bif.bus_addr, bif.bus_wdata, reg_sel});
      check("stall_first", snap, 64'({1'b1, 16'h1FFE, 16'hA000, 16'h0001}));
      for (int i = 0; i < 5; i++) begin
         ce = ~ce;
         tick();
         check("stall_hold", 64'({bif.bus_req, bif.bus_addr, bif.bus_wdata, reg_sel}), snap);
      end
      ce = 1'b1;
      bif.bus_ack = 1'b1;
      wait_idle("stall");

      // Reset during the third transfer of PUSH R
      exp_bus(1'b1, 16'h0FFE, 16'hA000, 16'h0001);
      exp_bus(1'b1, 16'h0FFC, 16'hA010, 16'h0002);
      do_start(16'h01DF, 16'h0000, 16'h1000);
      tick();
      tick();
      check("midop_third_addr", 64'({bif.bus_req, bif.bus_addr}), 64'({1'b1, 16'h0FFA}));
      reset_n = 1'b0;
      bif.bus_ack = 1'b0;
      tick();
      check_all_zero("midop_reset");
      reset_n = 1'b1;
      bif.bus_ack = 1'b1;
      tick();
      exp_bus(1'b1, 16'h2FFE, 16'hA000, 16'h0001);
      done_q.push_back(16'h2FFE);
      do_start(16'h0001, 16'h0000, 16'h3000);
      wait_idle("after_reset");
`ifdef STACK_SEQ_STATS_EN
      check("xfer_count", 64'(xfer_count), 64'd1);
`else
      check("xfer_count", 64'(xfer_count), 64'd0);
`endif

      repeat (2) tick();
      check("bus_q_drained", 64'(bus_q.size()), 64'd0);
      check("wb_q_drained", 64'(wb_q.size()), 64'd0);
      check("done_q_drained", 64'(done_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
